// File: rtl/uart_rx_if.sv
// Receive-side handshake bundle between uart_rx and the RX FIFO push logic.
// Carries the byte, its one-cycle strobes and the busy flag.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_done;
    logic                 rx_busy;
    logic                 frame_err;

    modport master (output rx_data, rx_done, rx_busy, frame_err);
    modport slave  (input  rx_data, rx_done, rx_busy, frame_err);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first. It oversamples the line on baud_tick and takes
// one centre sample per bit. Bytes and framing errors are reported as 1-clk strobes.
module uart_rx #(
    parameter int OVS       = 8,
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      baud_tick,
    input  logic      rx,
    uart_rx_if.master bus
);
    localparam int TICK_W = (OVS > 1) ? $clog2(OVS) : 1;
    localparam int BIT_W  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVS / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVS - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t               state, state_n;
    logic [TICK_W-1:0]    tick_cnt, tick_n;
    logic [BIT_W-1:0]     bit_cnt, bit_n;
    logic [DATA_BITS-1:0] sh, sh_n;
    logic [DATA_BITS-1:0] data_reg, data_n;
    logic                 done_reg, done_n;
    logic                 ferr_reg, ferr_n;
    logic                 sync1, rx_s, rx_p;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1    <= 1'b1;
            rx_s     <= 1'b1;
            rx_p     <= 1'b1;
            state    <= IDLE;
            tick_cnt <= '0;
            bit_cnt  <= '0;
            sh       <= '0;
            data_reg <= '0;
            done_reg <= 1'b0;
            ferr_reg <= 1'b0;
        end else begin
            sync1    <= rx;
            rx_s     <= sync1;
            rx_p     <= rx_s;
            state    <= state_n;
            tick_cnt <= tick_n;
            bit_cnt  <= bit_n;
            sh       <= sh_n;
            data_reg <= data_n;
            done_reg <= done_n;
            ferr_reg <= ferr_n;
        end
    end

    always_comb begin
        state_n = state;
        tick_n  = tick_cnt;
        bit_n   = bit_cnt;
        sh_n    = sh;
        data_n  = data_reg;
        done_n  = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE: begin
                // Edge detect requires a high first, so a held-low line cannot re-trigger.
                if (rx_p && !rx_s) begin
                    state_n = START;
                    tick_n  = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    tick_n = tick_cnt + TICK_W'(1);
                    if (tick_cnt == HALF_LAST) begin
                        if (!rx_s) begin
                            state_n = DATA;
                            tick_n  = '0;
                            bit_n   = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    tick_n = tick_cnt + TICK_W'(1);
                    if (tick_cnt == TICK_LAST) begin
                        sh_n   = {rx_s, sh[DATA_BITS-1:1]};
                        tick_n = '0;
                        if (bit_cnt == BIT_LAST) begin
                            state_n = STOP;
                        end else begin
                            bit_n = bit_cnt + BIT_W'(1);
                        end
                    end
                end
            end
            STOP: begin
                // Leaving at mid-stop lets a back-to-back start edge be caught on time.
                if (baud_tick) begin
                    tick_n = tick_cnt + TICK_W'(1);
                    if (tick_cnt == TICK_LAST) begin
                        tick_n  = '0;
                        state_n = IDLE;
                        if (rx_s) begin
                            data_n = sh;
                            done_n = 1'b1;
                        end else begin
                            ferr_n = 1'b1;
                        end
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.rx_data   = data_reg;
    assign bus.rx_done   = done_reg;
    assign bus.frame_err = ferr_reg;
    assign bus.rx_busy   = (state != IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as expected strobes when sent,
// and a monitor compares every rx_done/frame_err the receiver produces.
module tb_uart_rx;
    localparam int OVS          = 8;
    localparam int DATA_BITS    = 8;
    localparam int CLK_PER_TICK = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic baud_tick = 1'b0;
    logic rx = 1'b1;
    logic tick_en = 1'b1;

    uart_rx_if #(.DATA_BITS(DATA_BITS)) bus ();

    uart_rx #(.OVS(OVS), .DATA_BITS(DATA_BITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .baud_tick(baud_tick),
        .rx       (rx),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         err;
        logic [7:0] data;
    } exp_t;
    exp_t expq[$];
    exp_t ev;
    logic prev_strobe = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        int div;
        div = 0;
        forever begin
            @(negedge clk);
            baud_tick = tick_en && (div == CLK_PER_TICK - 1);
            div = (div + 1) % CLK_PER_TICK;
        end
    end

    task automatic wait_ticks(input int n);
        int c;
        c = 0;
        while (c < n) begin
            @(posedge clk);
            if (baud_tick) c++;
        end
        @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        wait_ticks(OVS);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input int stall_bit);
        send_bit(1'b0);
        for (int i = 0; i < DATA_BITS; i++) begin
            if (i == stall_bit) begin
                tick_en = 1'b0;
                repeat (100) @(negedge clk);
                chk("stall_busy_held", 32'(bus.rx_busy), 32'd1);
                tick_en = 1'b1;
            end
            send_bit(data[i]);
        end
        send_bit(stop);
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (bus.rx_done || bus.frame_err) begin
            chk("strobe_exclusive", 32'(bus.rx_done & bus.frame_err), 32'd0);
            chk("busy_low_at_strobe", 32'(bus.rx_busy), 32'd0);
            chk("strobe_one_clk", 32'(prev_strobe), 32'd0);
            if (expq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe: got done=%0b err=%0b data=%0h, expected none",
                         bus.rx_done, bus.frame_err, bus.rx_data);
            end else begin
                ev = expq.pop_front();
                chk("strobe_kind_frame_err", 32'(bus.frame_err), 32'(ev.err));
                chk("rx_data", 32'(bus.rx_data), 32'(ev.data));
            end
        end
        prev_strobe <= bus.rx_done || bus.frame_err;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
        chk("reset_rx_done", 32'(bus.rx_done), 32'd0);
        chk("reset_rx_busy", 32'(bus.rx_busy), 32'd0);
        chk("reset_frame_err", 32'(bus.frame_err), 32'd0);
        rst_n = 1'b1;
        wait_ticks(2 * OVS);

        // T1 single byte
        expq.push_back('{err: 1'b0, data: 8'h55});
        send_frame(8'h55, 1'b1, -1);
        wait_ticks(2 * OVS);

        // T3 glitch shorter than half a bit
        rx = 1'b0;
        wait_ticks(2);
        chk("glitch_busy_high", 32'(bus.rx_busy), 32'd1);
        rx = 1'b1;
        wait_ticks(OVS);
        chk("glitch_busy_back_low", 32'(bus.rx_busy), 32'd0);
        wait_ticks(OVS);

        // T4 framing error, then a break, then a good frame
        expq.push_back('{err: 1'b1, data: 8'h55});
        send_frame(8'h3C, 1'b0, -1);
        wait_ticks(2 * OVS);
        chk("break_stays_idle", 32'(bus.rx_busy), 32'd0);
        chk("break_keeps_data", 32'(bus.rx_data), 32'h55);
        rx = 1'b1;
        wait_ticks(OVS);
        expq.push_back('{err: 1'b0, data: 8'h81});
        send_frame(8'h81, 1'b1, -1);
        wait_ticks(2 * OVS);

        // T2 back-to-back frames with no idle between
        expq.push_back('{err: 1'b0, data: 8'hA3});
        expq.push_back('{err: 1'b0, data: 8'h0F});
        send_frame(8'hA3, 1'b1, -1);
        send_frame(8'h0F, 1'b1, -1);
        wait_ticks(2 * OVS);

        // T5 reset in the middle of data bit 4 of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx = 1'b1;
        wait_ticks(OVS / 2);
        chk("pre_reset_busy", 32'(bus.rx_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset_rx_data", 32'(bus.rx_data), 32'd0);
        chk("midreset_rx_busy", 32'(bus.rx_busy), 32'd0);
        chk("midreset_rx_done", 32'(bus.rx_done), 32'd0);
        chk("midreset_frame_err", 32'(bus.frame_err), 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        wait_ticks(2 * OVS);
        expq.push_back('{err: 1'b0, data: 8'h12});
        send_frame(8'h12, 1'b1, -1);
        wait_ticks(2 * OVS);

        // T6 baud_tick stalled for 100 clocks mid-frame
        expq.push_back('{err: 1'b0, data: 8'hC6});
        send_frame(8'hC6, 1'b1, 3);
        wait_ticks(2 * OVS);
        chk("final_rx_data", 32'(bus.rx_data), 32'hC6);
        chk("final_busy_idle", 32'(bus.rx_busy), 32'd0);
        chk("expected_queue_drained", 32'(expq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
